ble_packet_deframer: RTL and testbench

- Consumes the recovered bit stream (`update` strobe, `value` bit) from the matched-filter / timing-recovery front end.
- Searches for the 32-bit access address, with a programmable Hamming tolerance.
- After a match: dewhitens, deframes header, payload and CRC, and emits PDU bytes with a valid strobe.
- Reports packet start, done, abort and the CRC check to downstream logic (UART/host bridge).

---
 rtl/ble_pkg.sv | 33 +++
 rtl/ble_dewhiten_crc.sv | 58 +++++
 rtl/ble_packet_deframer.sv | 174 +++++++++++++++++
 tb/tb_ble_packet_deframer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ble_pkg.sv
// Shared definitions for the BLE packet deframer and related framing logic.
// Contents: the deframer state enum, the advertising-channel constants, the
// whitening LFSR geometry and a popcount helper for access-address matching.
package ble_pkg;

  typedef enum logic [2:0] {
    SEARCH  = 3'd0,
    HEADER  = 3'd1,
    PAYLOAD = 3'd2,
    CRC     = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [31:0] BLE_ADV_AA       = 32'h8E89BED6;
  localparam logic [23:0] BLE_ADV_CRC_INIT = 24'h555555;
  localparam logic [23:0] BLE_CRC_POLY     = 24'h00065B;

  // Whitening LFSR (x^7 + x^4 + 1): output is taken from WHT_OUT, which is
  // fed back into position 0 and XORed into position WHT_XOR.
  localparam int WHT_W   = 7;
  localparam int WHT_OUT = 6;
  localparam int WHT_XOR = 4;

  function automatic logic [5:0] popcount32(input logic [31:0] x);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, x[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/ble_dewhiten_crc.sv
// Whitening LFSR plus CRC-24 LFSR, shared between the RX deframer and a
// future TX framer.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load                preset whitening from channel and CRC from crc_init
//   step                advance whitening by one bit (and CRC if crc_en)
//   crc_en              1 = CRC absorbs bit_out on step, 0 = CRC frozen
//   bypass              1 = bit_out passes bit_in unwhitened
//   channel, crc_init   preset values used by load
//   bit_in / bit_out    raw bit in, (de)whitened bit out (combinational)
//   crc                 current CRC register
module ble_dewhiten_crc
  import ble_pkg::*;
#(
  parameter logic [23:0] CRC_POLY = BLE_CRC_POLY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        crc_en,
  input  logic        bypass,
  input  logic [5:0]  channel,
  input  logic [23:0] crc_init,
  input  logic        bit_in,
  output logic        bit_out,
  output logic [23:0] crc
);

  logic [WHT_W-1:0] wht;
  logic [WHT_W-1:0] wht_next;
  logic [23:0]      crc_next;

  assign bit_out = bit_in ^ (~bypass & wht[WHT_OUT]);

  always_comb begin
    wht_next          = {wht[WHT_W-2:0], wht[WHT_OUT]};
    wht_next[WHT_XOR] = wht[WHT_XOR-1] ^ wht[WHT_OUT];
    crc_next          = {crc[22:0], 1'b0} ^ ((bit_out ^ crc[23]) ? CRC_POLY : 24'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wht <= '0;
      crc <= '0;
    end else if (load) begin
      // Position 0 is always 1; channel[5] lands in position 1, channel[0] in 6.
      wht <= {channel[0], channel[1], channel[2], channel[3], channel[4], channel[5], 1'b1};
      crc <= crc_init;
    end else if (step) begin
      wht <= wht_next;
      if (crc_en) begin
        crc <= crc_next;
      end
    end
  end

endmodule

// File: rtl/ble_packet_deframer.sv
// BLE packet deframer: finds the access address in the recovered bit stream
// (with a Hamming tolerance), then dewhitens and deframes header, payload and
// CRC, emitting PDU bytes and packet status.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   update, value         bit strobe (rising edge = new bit) and data bit
//   access_addr           expected access address, bit 0 received first
//   channel, crc_init     whitening seed and CRC preset
//   dewhiten_en           1 = remove whitening from PDU and CRC bits
//   byte_out/byte_valid   PDU byte (LSB first received) and its strobe
//   byte_idx, pdu_len     byte position in the PDU, latched length field
//   pkt_start/pkt_done    access-address match / end-of-CRC pulses
//   crc_ok                CRC result, valid with pkt_done, held to next start
//   pkt_abort             length field above MAX_LEN
//   state_dbg             current FSM state
module ble_packet_deframer
  import ble_pkg::*;
#(
  parameter int          MAX_ERR  = 1,
  parameter int          MAX_LEN  = 37,
  parameter logic [23:0] CRC_POLY = BLE_CRC_POLY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        update,
  input  logic        value,
  input  logic [31:0] access_addr,
  input  logic [5:0]  channel,
  input  logic [23:0] crc_init,
  input  logic        dewhiten_en,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic [7:0]  byte_idx,
  output logic [7:0]  pdu_len,
  output logic        pkt_start,
  output logic        pkt_done,
  output logic        crc_ok,
  output logic        pkt_abort,
  output logic [2:0]  state_dbg
);

  localparam logic [5:0] ERR_LIM = 6'(MAX_ERR);
  localparam logic [7:0] LEN_LIM = 8'(MAX_LEN);

  state_t      state, state_next;
  logic        upd_q, armed, bit_en;
  logic [31:0] aa_sr, aa_next;
  logic [5:0]  aa_cnt;
  logic [4:0]  bit_cnt;
  logic [7:0]  byte_cnt;
  logic [7:0]  sh, byte_new;
  logic [23:0] rx_crc, rx_crc_next, crc_calc;
  logic        d, match, in_pdu, in_frame, byte_done, crc_last, bypass;

  // armed blocks a bit in the first cycle after reset when update is already high.
  assign bit_en    = update & ~upd_q & armed;
  assign bypass    = ~dewhiten_en;
  assign state_dbg = state;

  ble_dewhiten_crc #(.CRC_POLY(CRC_POLY)) u_dwc (
    .clk      (clk),
    .rst      (rst),
    .load     (match),
    .step     (bit_en & in_frame),
    .crc_en   (in_pdu),
    .bypass   (bypass),
    .channel  (channel),
    .crc_init (crc_init),
    .bit_in   (value),
    .bit_out  (d),
    .crc      (crc_calc)
  );

  always_comb begin
    aa_next     = {value, aa_sr[31:1]};
    in_pdu      = (state == HEADER) || (state == PAYLOAD);
    in_frame    = in_pdu || (state == CRC);
    // Matching is evaluated on the register contents including this bit, so
    // 31 registered shifts plus the current one make a full window.
    match       = bit_en && (state == SEARCH) && (aa_cnt >= 6'd31) &&
                  (popcount32(aa_next ^ access_addr) <= ERR_LIM);
    byte_new    = {d, sh[7:1]};
    byte_done   = bit_en && in_pdu && (bit_cnt[2:0] == 3'd7);
    rx_crc_next = {rx_crc[22:0], d};
    crc_last    = bit_en && (state == CRC) && (bit_cnt == 5'd23);

    state_next = state;
    case (state)
      SEARCH:  if (match) state_next = HEADER;
      HEADER:  if (byte_done && (byte_cnt == 8'd1)) begin
                 if (byte_new > LEN_LIM)      state_next = SEARCH;
                 else if (byte_new == 8'd0)   state_next = CRC;
                 else                         state_next = PAYLOAD;
               end
      PAYLOAD: if (byte_done && (byte_cnt == pdu_len + 8'd1)) state_next = CRC;
      CRC:     if (crc_last) state_next = DONE;
      DONE:    state_next = SEARCH;
      default: state_next = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEARCH;
      upd_q      <= 1'b0;
      armed      <= 1'b0;
      aa_sr      <= '0;
      aa_cnt     <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      sh         <= '0;
      rx_crc     <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      byte_idx   <= '0;
      pdu_len    <= '0;
      pkt_start  <= 1'b0;
      pkt_done   <= 1'b0;
      crc_ok     <= 1'b0;
      pkt_abort  <= 1'b0;
    end else begin
      state      <= state_next;
      upd_q      <= update;
      armed      <= 1'b1;
      byte_valid <= 1'b0;
      pkt_start  <= match;
      pkt_done   <= 1'b0;
      pkt_abort  <= 1'b0;

      // The search window restarts from empty whenever a packet is in flight,
      // so a return to SEARCH always begins with a cleared shift count.
      if (state != SEARCH || match) begin
        aa_sr  <= '0;
        aa_cnt <= '0;
      end else if (bit_en) begin
        aa_sr <= aa_next;
        if (aa_cnt != 6'd32) aa_cnt <= aa_cnt + 6'd1;
      end

      if (match) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
        crc_ok   <= 1'b0;
      end

      if (bit_en && in_pdu) begin
        sh <= byte_new;
        if (byte_done) begin
          bit_cnt    <= '0;
          byte_out   <= byte_new;
          byte_valid <= 1'b1;
          byte_idx   <= byte_cnt;
          byte_cnt   <= byte_cnt + 8'd1;
          if (byte_cnt == 8'd1) begin
            pdu_len   <= byte_new;
            pkt_abort <= (byte_new > LEN_LIM);
          end
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end

      if (bit_en && (state == CRC)) begin
        rx_crc  <= rx_crc_next;
        bit_cnt <= bit_cnt + 5'd1;
        if (crc_last) begin
          pkt_done <= 1'b1;
          crc_ok   <= (rx_crc_next == crc_calc);
        end
      end
    end
  end

endmodule

// File: tb/tb_ble_packet_deframer.sv
module tb_ble_packet_deframer;
  import ble_pkg::*;

  logic        clk = 1'b0;
  logic        rst, update, value, dewhiten_en;
  logic [31:0] access_addr;
  logic [5:0]  channel;
  logic [23:0] crc_init;

  logic [7:0] byte_out, byte_idx, pdu_len;
  logic       byte_valid, pkt_start, pkt_done, crc_ok, pkt_abort;
  logic [2:0] state_dbg;

  logic [7:0] byte_out_e0, byte_idx_e0, pdu_len_e0;
  logic       byte_valid_e0, pkt_start_e0, pkt_done_e0, crc_ok_e0, pkt_abort_e0;
  logic [2:0] state_dbg_e0;

  always #5 clk = ~clk;

  ble_packet_deframer #(.MAX_ERR(1), .MAX_LEN(37), .CRC_POLY(BLE_CRC_POLY)) dut (
    .clk(clk), .rst(rst), .update(update), .value(value), .access_addr(access_addr),
    .channel(channel), .crc_init(crc_init), .dewhiten_en(dewhiten_en),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_idx(byte_idx), .pdu_len(pdu_len),
    .pkt_start(pkt_start), .pkt_done(pkt_done), .crc_ok(crc_ok), .pkt_abort(pkt_abort),
    .state_dbg(state_dbg)
  );

  ble_packet_deframer #(.MAX_ERR(0), .MAX_LEN(37), .CRC_POLY(BLE_CRC_POLY)) dut_e0 (
    .clk(clk), .rst(rst), .update(update), .value(value), .access_addr(access_addr),
    .channel(channel), .crc_init(crc_init), .dewhiten_en(dewhiten_en),
    .byte_out(byte_out_e0), .byte_valid(byte_valid_e0), .byte_idx(byte_idx_e0),
    .pdu_len(pdu_len_e0), .pkt_start(pkt_start_e0), .pkt_done(pkt_done_e0),
    .crc_ok(crc_ok_e0), .pkt_abort(pkt_abort_e0), .state_dbg(state_dbg_e0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int         cyc = 0;
  int         edge_cyc = 0;
  logic       upd_prev = 1'b0;
  logic [7:0] got_idx[$];
  logic [7:0] got_byte[$];
  int         n_start, n_done, n_abort, n_start0, n_bytes0;
  logic       got_crc_ok, abort_b1;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    upd_prev <= update;
    if (update && !upd_prev) edge_cyc <= cyc;
  end

  always @(negedge clk) begin
    if (byte_valid) begin
      got_idx.push_back(byte_idx);
      got_byte.push_back(byte_out);
      check("byte_valid lag", 32'(cyc), 32'(edge_cyc + 1));
    end
    if (pkt_start) n_start++;
    if (pkt_done) begin
      n_done++;
      got_crc_ok = crc_ok;
    end
    if (pkt_abort) begin
      n_abort++;
      abort_b1 = byte_valid && (byte_idx == 8'd1);
    end
    if (pkt_start_e0) n_start0++;
    if (byte_valid_e0) n_bytes0++;
  end

  task automatic clear_mon();
    got_idx.delete();
    got_byte.delete();
    n_start = 0; n_done = 0; n_abort = 0; n_start0 = 0; n_bytes0 = 0;
    got_crc_ok = 1'b0; abort_b1 = 1'b0;
  endtask

  // ---------------- reference model ----------------
  bit         tx_bits[$];
  logic [7:0] exp_bytes[$];

  task automatic make_packet(input logic [31:0] aa, input logic [5:0] ch, input logic [23:0] cinit,
                             input bit wh, input int len, input int corrupt);
    logic [7:0]  pdu[$];
    bit          pbits[$];
    logic [23:0] c;
    logic [6:0]  lf;
    logic [7:0]  b;
    bit          o, fb;
    logic [31:0] lenv;
    lenv = 32'(len);
    pdu.push_back(8'h02);
    pdu.push_back(lenv[7:0]);
    for (int i = 0; i < len; i++) pdu.push_back(8'($urandom));
    for (int i = 0; i < pdu.size(); i++)
      for (int k = 0; k < 8; k++) pbits.push_back(pdu[i][k]);
    c = cinit;
    for (int i = 0; i < pbits.size(); i++) begin
      fb = pbits[i] ^ c[23];
      c  = {c[22:0], 1'b0} ^ (fb ? BLE_CRC_POLY : 24'd0);
    end
    if (corrupt >= 0) pbits[16 + corrupt] = ~pbits[16 + corrupt];
    exp_bytes.delete();
    for (int i = 0; i < pdu.size(); i++) begin
      for (int k = 0; k < 8; k++) b[k] = pbits[8*i + k];
      exp_bytes.push_back(b);
    end
    for (int k = 23; k >= 0; k--) pbits.push_back(c[k]);
    tx_bits.delete();
    for (int i = 0; i < 8; i++) tx_bits.push_back((i % 2) == 0);
    for (int i = 0; i < 32; i++) tx_bits.push_back(aa[i]);
    lf = {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], 1'b1};
    for (int i = 0; i < pbits.size(); i++) begin
      o  = lf[6];
      tx_bits.push_back(pbits[i] ^ (wh & o));
      lf = {lf[5:0], o} ^ (o ? 7'h10 : 7'h00);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_bit(input bit b, input int hi, input int lo);
    @(negedge clk);
    value  = b;
    update = 1'b1;
    repeat (hi) @(negedge clk);
    update = 1'b0;
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic send_bits(input int from, input int to, input int hi, input int lo);
    for (int i = from; i < to; i++) send_bit(tx_bits[i], hi, lo);
  endtask

  task automatic check_zero(input string tag);
    check(tag, {byte_out, byte_valid, byte_idx, pdu_len, pkt_start, pkt_done,
                crc_ok, pkt_abort, state_dbg}, 32'd0);
  endtask

  task automatic check_result(input string tag, input int es, input int nexp, input int ed,
                              input int eok, input int eab, input int len);
    int n;
    check({tag, " pkt_start"}, 32'(n_start), 32'(es));
    check({tag, " byte count"}, 32'(got_idx.size()), 32'(nexp));
    n = (got_idx.size() < exp_bytes.size()) ? got_idx.size() : exp_bytes.size();
    if (n > nexp) n = nexp;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s byte_idx[%0d]", tag, i), 32'(got_idx[i]), 32'(i));
      check($sformatf("%s byte_out[%0d]", tag, i), 32'(got_byte[i]), 32'(exp_bytes[i]));
    end
    check({tag, " pkt_done"}, 32'(n_done), 32'(ed));
    if (ed != 0) begin
      check({tag, " crc_ok"}, 32'(got_crc_ok), 32'(eok));
      check({tag, " crc_ok held"}, 32'(crc_ok), 32'(eok));
    end
    check({tag, " pkt_abort"}, 32'(n_abort), 32'(eab));
    if (eab != 0) check({tag, " abort with byte1"}, 32'(abort_b1), 32'd1);
    if (es != 0) check({tag, " pdu_len"}, 32'(pdu_len), 32'(len));
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] flip;
    int          len;
    int          corrupt;
    logic [5:0]  ch;
    logic        wh;
    logic        rnd;
    logic        es;
    logic        es0;
    logic        ed;
    logic        eok;
    logic        eab;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        v;
    logic [5:0]  ch;
    logic [23:0] cinit;
    int          len, nexp;

    //            flip           len     corrupt ch     wh    rnd   es    es0   ed    eok   eab
    vecs[0] = '{32'h0,        6,  -1, 6'd37, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{32'h0,        6,  20, 6'd37, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'h20,       6,  -1, 6'd37, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{32'h01000020, 6,  -1, 6'd37, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h0,        0,  -1, 6'd38, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{32'h0,        38, -1, 6'd39, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{32'h0,        37, -1, 6'd37, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{32'h0,        0,  -1, 6'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; update = 1'b0; value = 1'b0;
    access_addr = BLE_ADV_AA; channel = 6'd37; crc_init = BLE_ADV_CRC_INIT; dewhiten_en = 1'b1;
    clear_mon();
    repeat (3) @(negedge clk);
    check_zero("reset outputs");
    rst = 1'b0;
    @(negedge clk);
    check_zero("outputs after release");

    for (int r = 0; r < 8; r++) begin
      v     = vecs[r];
      ch    = v.ch;
      len   = v.len;
      cinit = BLE_ADV_CRC_INIT;
      if (v.rnd) begin
        ch    = 6'($urandom_range(0, 39));
        len   = $urandom_range(1, 37);
        cinit = 24'($urandom);
      end
      channel = ch; crc_init = cinit; dewhiten_en = v.wh;
      make_packet(BLE_ADV_AA ^ v.flip, ch, cinit, v.wh, len, v.corrupt);
      clear_mon();
      send_bits(0, tx_bits.size(), 1, 3);
      repeat (8) @(negedge clk);
      nexp = !v.es ? 0 : (v.eab ? 2 : len + 2);
      check_result($sformatf("row%0d", r), int'(v.es), nexp, int'(v.ed), int'(v.eok),
                   int'(v.eab), len);
      check($sformatf("row%0d pkt_start maxerr0", r), 32'(n_start0), 32'(v.es0));
      check($sformatf("row%0d bytes maxerr0", r), 32'(n_bytes0), 32'(v.es0 ? nexp : 0));
    end

    // Strobe handling: long-held update and 1 MHz pulses, one bit per edge.
    channel = 6'd37; crc_init = BLE_ADV_CRC_INIT; dewhiten_en = 1'b1;
    make_packet(BLE_ADV_AA, 6'd37, BLE_ADV_CRC_INIT, 1'b1, 3, -1);
    clear_mon();
    send_bit(tx_bits[0], 40, 8);
    send_bits(1, 40, 8, 8);
    send_bit(tx_bits[40], 40, 8);
    send_bits(41, tx_bits.size(), 8, 8);
    repeat (20) @(negedge clk);
    check_result("strobe", 1, 5, 1, 1, 0, 3);

    // Reset in the middle of payload byte 3 (PDU byte 5).
    make_packet(BLE_ADV_AA, 6'd37, BLE_ADV_CRC_INIT, 1'b1, 10, -1);
    clear_mon();
    send_bits(0, 8 + 32 + 44, 1, 3);
    check("midreset bytes before", 32'(got_idx.size()), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midreset outputs");
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("midreset pkt_done", 32'(n_done), 32'd0);
    check("midreset pkt_abort", 32'(n_abort), 32'd0);
    make_packet(BLE_ADV_AA, 6'd37, BLE_ADV_CRC_INIT, 1'b1, 5, -1);
    clear_mon();
    send_bits(0, tx_bits.size(), 1, 3);
    repeat (8) @(negedge clk);
    check_result("after reset", 1, 7, 1, 1, 0, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
